// File: rtl/uart_frame_parser.sv
// uart_frame_parser
// Receives bytes from a UART receiver, finds frames of the form
// SYNC_BYTE, LEN, LEN payload bytes, CSUM, and verifies the checksum
// CSUM = (LEN + sum of payload) mod 256.
// Payload bytes are buffered while the frame arrives. Only a frame whose
// checksum matches is replayed on the out_* handshake interface.
// Bad lengths and bad checksums each produce a one-cycle error pulse.
// Bytes that arrive while a frame is being drained are dropped and flagged.
//
// Optional feature: define FRAME_TIMEOUT_EN to enable the inter-byte timeout.
// A frame that stalls for TIMEOUT_CYCLES clocks in LEN/PAYLOAD/CSUM is
// abandoned and the timeout output pulses. Without the macro, timeout is
// tied low and the parser waits indefinitely.
module uart_frame_parser #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         MAX_LEN        = 16,
  parameter int         TIMEOUT_CYCLES = 52080
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       crc_err,
  output logic       len_err,
  output logic       overrun,
  output logic       timeout
);

  // Buffer address width; at least one bit so MAX_LEN=1 still elaborates
  localparam int         AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  typedef enum logic [2:0] {
    S_HUNT,
    S_LEN,
    S_PAYLOAD,
    S_CSUM,
    S_DRAIN
  } state_t;

  state_t     state;
  logic [7:0] len_reg;
  logic [7:0] idx_reg;
  logic [7:0] rd_idx_reg;
  logic [7:0] sum_reg;
  logic [7:0] rd_idx_next;
  logic       tmo_fire;

  // Payload storage. It has no reset: a discarded frame is simply overwritten.
  logic [7:0] buffer [0:MAX_LEN-1];

  assign rd_idx_next = rd_idx_reg + 8'd1;

  // Payload buffer write port, one byte per accepted payload strobe
  always_ff @(posedge clk) begin
    if (state == S_PAYLOAD && rx_valid) begin
      buffer[idx_reg[AW-1:0]] <= rx_data;
    end
  end

`ifdef FRAME_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tmo_cnt_reg;
  logic          in_frame;

  // The timer only runs while the parser is partway through a frame header or body
  assign in_frame = (state == S_LEN) || (state == S_PAYLOAD) || (state == S_CSUM);

  // A byte arriving on the expiry cycle takes priority over the timeout
  assign tmo_fire = in_frame && !rx_valid && (tmo_cnt_reg == TW'(TIMEOUT_CYCLES - 1));

  // Inter-byte silence counter and the registered timeout pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt_reg <= '0;
      timeout     <= 1'b0;
    end else begin
      timeout <= tmo_fire;
      if (rx_valid || !in_frame || tmo_fire) begin
        tmo_cnt_reg <= '0;
      end else begin
        tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
      end
    end
  end
`else
  assign tmo_fire = 1'b0;
  assign timeout  = 1'b0;
`endif

  // Frame FSM with registered outputs. Error pulses default low every cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_HUNT;
      len_reg    <= 8'd0;
      idx_reg    <= 8'd0;
      rd_idx_reg <= 8'd0;
      sum_reg    <= 8'd0;
      out_data   <= 8'h00;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      crc_err    <= 1'b0;
      len_err    <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      crc_err <= 1'b0;
      len_err <= 1'b0;
      overrun <= 1'b0;
      case (state)
        S_HUNT: begin
          if (rx_valid && rx_data == SYNC_BYTE) begin
            state <= S_LEN;
          end
        end
        S_LEN: begin
          if (rx_valid) begin
            if (rx_data == 8'd0 || rx_data > MAX_LEN_B) begin
              len_err <= 1'b1;
              state   <= S_HUNT;
            end else begin
              len_reg <= rx_data;
              sum_reg <= rx_data;
              idx_reg <= 8'd0;
              state   <= S_PAYLOAD;
            end
          end else if (tmo_fire) begin
            state <= S_HUNT;
          end
        end
        S_PAYLOAD: begin
          if (rx_valid) begin
            sum_reg <= sum_reg + rx_data;
            idx_reg <= idx_reg + 8'd1;
            if (idx_reg == len_reg - 8'd1) begin
              state <= S_CSUM;
            end
          end else if (tmo_fire) begin
            state <= S_HUNT;
          end
        end
        S_CSUM: begin
          if (rx_valid) begin
            if (rx_data == sum_reg) begin
              // Prefetch the first payload byte so out_valid rises one cycle later
              state      <= S_DRAIN;
              rd_idx_reg <= 8'd0;
              out_valid  <= 1'b1;
              out_data   <= buffer[0];
              out_last   <= (len_reg == 8'd1);
            end else begin
              crc_err <= 1'b1;
              state   <= S_HUNT;
            end
          end else if (tmo_fire) begin
            state <= S_HUNT;
          end
        end
        S_DRAIN: begin
          // The receiver cannot be stalled, so a byte arriving here is lost
          if (rx_valid) begin
            overrun <= 1'b1;
          end
          if (out_valid && out_ready) begin
            if (out_last) begin
              state     <= S_HUNT;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_data  <= 8'h00;
            end else begin
              rd_idx_reg <= rd_idx_next;
              out_data   <= buffer[rd_idx_next[AW-1:0]];
              out_last   <= (rd_idx_next == len_reg - 8'd1);
            end
          end
        end
        default: begin
          state <= S_HUNT;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_frame_parser.md
UART_FRAME_PARSER -- requirements
Module: uart_frame_parser

Interface
REQ-001: Parameter SYNC_BYTE, default 8'hA5, frame start marker.
REQ-002: Parameter MAX_LEN, default 16, maximum payload length in bytes (1..255).
REQ-003: Parameter TIMEOUT_CYCLES, default 52080, inter-byte timeout in clk cycles (10 bit times at 50 MHz / 9600 baud).
REQ-004: clk  input  1  system clock, all logic on rising edge.
REQ-005: reset  input  1  asynchronous, active-high reset.
REQ-006: rx_data  input  8  received byte from the UART receiver.
REQ-007: rx_valid  input  1  single-cycle strobe; rx_data valid in the same cycle.
REQ-008: out_data  output  8  payload byte of a verified frame.
REQ-009: out_valid  output  1  out_data valid.
REQ-010: out_ready  input  1  downstream accepts out_data.
REQ-011: out_last  output  1  high with the final payload byte of a frame.
REQ-012: crc_err  output  1  one-cycle pulse on checksum mismatch.
REQ-013: len_err  output  1  one-cycle pulse on illegal length byte.
REQ-014: overrun  output  1  one-cycle pulse when a byte is dropped during DRAIN.
REQ-015: timeout  output  1  one-cycle pulse on inter-byte timeout (only with FRAME_TIMEOUT_EN).

Function
REQ-016: Frame format SHALL be SYNC_BYTE, LEN, LEN payload bytes, CSUM; CSUM = (LEN + sum of payload) mod 256, 8-bit wrap.
REQ-017: FSM states SHALL be HUNT, LEN, PAYLOAD, CSUM, DRAIN; a byte is consumed only in a cycle with rx_valid=1.
REQ-018: HUNT: byte == SYNC_BYTE -> LEN; any other byte ignored, stay HUNT, no error.
REQ-019: LEN: byte 0 or byte > MAX_LEN -> len_err pulse next cycle, -> HUNT; else store LEN, seed sum = LEN, index = 0, -> PAYLOAD.
REQ-020: PAYLOAD: write byte to buffer[index], add to sum, increment index; after byte LEN -> CSUM.
REQ-021: CSUM: byte == sum -> DRAIN, rd index = 0; mismatch -> crc_err pulse next cycle, -> HUNT, buffer discarded.
REQ-022: out_valid SHALL assert in the cycle after the CSUM byte is consumed (1-cycle latency) and remain high until the last byte transfers.
REQ-023: In DRAIN, out_data = buffer[rd index]; out_last = 1 when rd index == LEN-1; transfer occurs when out_valid && out_ready; rd index advances per transfer.
REQ-024: out_data/out_last SHALL hold stable while out_valid=1 and out_ready=0.
REQ-025: After the out_last transfer, FSM -> HUNT; out_valid = 0 the following cycle.
REQ-026: rx_valid in DRAIN: byte dropped, overrun pulse next cycle, DRAIN unaffected; a SYNC_BYTE arriving in DRAIN is also dropped.
REQ-027: Error pulses SHALL be exactly one cycle wide and mutually exclusive per cycle.

Reset
REQ-028: Reset SHALL force state HUNT, indices, sum and timeout counter to 0; out_valid, out_last, crc_err, len_err, overrun, timeout to 0; out_data to 8'h00.
REQ-029: Reset mid-frame or mid-DRAIN SHALL discard the frame; no partial output after release.

Configuration
REQ-030: Macro FRAME_TIMEOUT_EN defined: counter clears on every rx_valid and in HUNT/DRAIN; in LEN/PAYLOAD/CSUM, reaching TIMEOUT_CYCLES without rx_valid -> timeout pulse, -> HUNT.
REQ-031: rx_valid in the same cycle as timeout expiry SHALL win: byte consumed, no timeout.
REQ-032: Macro undefined: no counter logic; timeout output tied to 0; FSM waits indefinitely.

Verification
REQ-033: Bytes A5 03 11 22 33 69, out_ready=1 -> out 11,22,33 on consecutive cycles, out_last with 33, no error pulses.
REQ-034: Bytes A5 02 10 20 00 -> crc_err one pulse, no out_valid, next valid frame parsed normally.
REQ-035: Bytes A5 00 then A5 11 (MAX_LEN=16) -> two len_err pulses, FSM in HUNT.
REQ-036: Valid frame with out_ready=0 for 20 cycles, 2 bytes strobed meanwhile -> 2 overrun pulses, out_data held, full payload delivered once out_ready=1.
REQ-037: FRAME_TIMEOUT_EN, TIMEOUT_CYCLES=100: A5 04 01 then silence -> timeout pulse 100 cycles after last strobe, following A5 01 7E 7F delivers 7E with out_last.
REQ-038: Reset asserted after 2 of 4 payload bytes -> all outputs 0, following complete frame parsed correctly.
